neighbor_index_allocator: RTL and testbench
===========================================

// Module: neighbor_index_allocator
// PURPOSE
//  Upstream control stage for the neighbour table. Takes overheard same-cluster
//  packet fields (membership request, data, SOS) from QTableUpdate and filters out
//  self and foreign-cluster senders. Searches a local node-ID tag array for an
//  existing slot, or allocates the next free one, then drives one registered
//  write strobe plus slot index and payload into neighborTable.
// PARAMETERS
//  WORD_WIDTH   16       width of every packet field
//  NUM_ENTRIES  32       neighbour slots; power of two, >=2
//  MY_NODE_ID   16'h000C this node's ID; packets carrying it are filtered
// PORTS
//  clk            in  1     clock, rising edge
//  nrst           in  1     reset, asynchronous, active-low
//  hb_reset       in  1     heartbeat reset: forget all neighbours
//  my_chosen_ch   in  WW    this node's current cluster head
//  pkt_valid      in  1     overheard-packet fields valid
//  pkt_ready      out 1     block can accept a packet this cycle
//  pkt_node_id    in  WW    sender ID
//  pkt_chosen_ch  in  WW    sender's cluster head
//  pkt_hops, pkt_qvalue, pkt_energy, pkt_ch_hops  in  WW  payload fields
//  wr_en          out 1     one-cycle write strobe to neighborTable
//  wr_index       out IW    slot written; IW=$clog2(NUM_ENTRIES)
//  wr_new         out 1     with wr_en: 1 = freshly allocated, 0 = refresh
//  wr_node_id, wr_chosen_ch, wr_hops, wr_qvalue, wr_energy, wr_ch_hops  out WW
//                           latched payload, stable while wr_en is high
//  neighbor_count out IW+1  slots in use (0..NUM_ENTRIES)
//  table_full     out 1     neighbor_count == NUM_ENTRIES
//  pkt_dropped    out 1     one-cycle pulse: packet filtered or table full
// BEHAVIOUR
//  - Reset: every output is 0. State is S_IDLE. Count is 0. All tags are 0.
//  - Outputs are registered, except pkt_ready = (state==S_IDLE) && !hb_reset.
//  - Accept happens when pkt_valid && pkt_ready (cycle 0). All pkt_* fields are latched then.
//  - Filter at accept: if node_id==MY_NODE_ID or chosen_ch!=my_chosen_ch,
//    pkt_dropped pulses in cycle 1 and the FSM stays in S_IDLE.
//  - Let cnt = count at accept. Slots 0..cnt-1 are always the valid ones;
//    allocation is contiguous.
//  - S_SEARCH compares one slot per cycle: slot i in cycle 1+i.
//  - Hit at slot i: S_WRITE in cycle i+2 with wr_en=1, wr_index=i, wr_new=0.
//    The count does not change.
//  - Miss with cnt<NUM_ENTRIES: S_WRITE in cycle cnt+1 with wr_index=cnt, wr_new=1.
//    The tag is written and the count increments on that edge.
//    cnt==0 goes from S_IDLE straight to S_WRITE (cycle 1).
//  - Miss with cnt==NUM_ENTRIES: pkt_dropped pulses in cycle cnt+1, no wr_en,
//    and the FSM returns to S_IDLE.
//  - S_WRITE always lasts 1 cycle, then S_IDLE. pkt_ready is high the cycle after.
//  - FSM states: S_IDLE, S_SEARCH, S_WRITE, S_CLEAR.
//    S_IDLE: on hb_reset -> S_CLEAR; on accept -> filter, S_SEARCH or S_WRITE.
//  - hb_reset has priority in every state and aborts a search or write in flight
//    (no wr_en is issued). S_CLEAR zeroes count and tags in 1 cycle, then S_IDLE.
//  - hb_reset together with pkt_valid in S_IDLE: pkt_ready=0, so the packet is not taken.
//  - Duplicate IDs never occupy two slots.
//  - Count saturates at NUM_ENTRIES and never wraps.
//  - Asynchronous nrst mid-search: immediate return to the reset state, with no
//    partial write.
// STRUCTURE
//  - neighbor_pkg holds: WORD_WIDTH, MY_NODE_ID default, the state enum
//    (neighbor_alloc_state_t), and the neighbour payload struct shared with
//    neighborTable.
//  - Sub-module neighbor_tag_store: the NUM_ENTRIES x WORD_WIDTH tag array with
//    one read port (index -> id), one write port, and a synchronous clear.
//  - FSM, search pointer and count stay in this top.
// TESTING
//  1. Reset, then send id=5, ch=my_ch=3 -> wr_en in cycle 1, wr_index=0, wr_new=1;
//     count becomes 1.
//  2. Load ids 5,6,7, then resend id=7 -> hit at slot 2; wr_en in cycle 4,
//     wr_index=2, wr_new=0; count stays 3.
//  3. Send id=16'h000C, then id=9 with ch!=my_ch -> pkt_dropped pulses each time,
//     no wr_en, count unchanged.
//  4. Fill 32 distinct ids, then send a new id -> table_full=1, pkt_dropped in
//     cycle 33, no wr_en; resending an existing id still refreshes.
//  5. Assert hb_reset in cycle 2 of a 5-slot search -> no wr_en; count=0 after
//     S_CLEAR; the next id gets slot 0.
//  6. hb_reset and pkt_valid together in S_IDLE -> pkt_ready=0 and the packet is
//     not consumed; deassert hb_reset, the packet is accepted and written to slot 0.

Source files
------------

// File: rtl/neighbor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neighbor_pkg                                                         |
// | Shared widths, defaults, allocator states and neighbour payload.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package neighbor_pkg;

  localparam int          c_word_width  = 16;
  localparam int          c_num_entries = 32;
  localparam logic [15:0] c_my_node_id  = 16'h000C;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_WRITE  = 2'd2,
    S_CLEAR  = 2'd3
  } neighbor_alloc_state_t;

  typedef struct packed {
    logic [c_word_width-1:0] node_id;
    logic [c_word_width-1:0] chosen_ch;
    logic [c_word_width-1:0] hops;
    logic [c_word_width-1:0] qvalue;
    logic [c_word_width-1:0] energy;
    logic [c_word_width-1:0] ch_hops;
  } neighbor_payload_t;

endpackage
`default_nettype wire

// File: rtl/neighbor_index_allocator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neighbor_index_allocator_if                                          |
// | Overheard-packet input and neighbour-table write bundle.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface neighbor_index_allocator_if
  import neighbor_pkg::*;
#(
  parameter int WORD_WIDTH  = c_word_width,
  parameter int NUM_ENTRIES = c_num_entries
);
  localparam int IW = $clog2(NUM_ENTRIES);

  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [WORD_WIDTH-1:0] pkt_node_id;
  logic [WORD_WIDTH-1:0] pkt_chosen_ch;
  logic [WORD_WIDTH-1:0] pkt_hops;
  logic [WORD_WIDTH-1:0] pkt_qvalue;
  logic [WORD_WIDTH-1:0] pkt_energy;
  logic [WORD_WIDTH-1:0] pkt_ch_hops;

  logic                  wr_en;
  logic [IW-1:0]         wr_index;
  logic                  wr_new;
  logic [WORD_WIDTH-1:0] wr_node_id;
  logic [WORD_WIDTH-1:0] wr_chosen_ch;
  logic [WORD_WIDTH-1:0] wr_hops;
  logic [WORD_WIDTH-1:0] wr_qvalue;
  logic [WORD_WIDTH-1:0] wr_energy;
  logic [WORD_WIDTH-1:0] wr_ch_hops;

  // slave: the allocator (consumes packets, drives the table write)
  modport slave (
    input  pkt_valid, pkt_node_id, pkt_chosen_ch, pkt_hops, pkt_qvalue,
           pkt_energy, pkt_ch_hops,
    output pkt_ready, wr_en, wr_index, wr_new, wr_node_id, wr_chosen_ch,
           wr_hops, wr_qvalue, wr_energy, wr_ch_hops
  );

  modport master (
    output pkt_valid, pkt_node_id, pkt_chosen_ch, pkt_hops, pkt_qvalue,
           pkt_energy, pkt_ch_hops,
    input  pkt_ready, wr_en, wr_index, wr_new, wr_node_id, wr_chosen_ch,
           wr_hops, wr_qvalue, wr_energy, wr_ch_hops
  );

endinterface
`default_nettype wire

// File: rtl/neighbor_tag_store.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neighbor_tag_store                                                   |
// | Node-ID tag array: one async read port, one write port, sync clear.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module neighbor_tag_store
  import neighbor_pkg::*;
#(
  parameter int WORD_WIDTH  = c_word_width,
  parameter int NUM_ENTRIES = c_num_entries
) (
  input  wire logic                           clk,
  input  wire logic                           nrst,
  input  wire logic                           clr,
  input  wire logic                           we,
  input  wire logic [$clog2(NUM_ENTRIES)-1:0] wr_index,
  input  wire logic [WORD_WIDTH-1:0]          wr_data,
  input  wire logic [$clog2(NUM_ENTRIES)-1:0] rd_index,
  output logic      [WORD_WIDTH-1:0]          rd_data
);

  logic [WORD_WIDTH-1:0] r_tags [NUM_ENTRIES];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_tags[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_tags[i] <= '0;
    end else if (we) begin
      r_tags[wr_index] <= wr_data;
    end
  end

  assign rd_data = r_tags[rd_index];

endmodule
`default_nettype wire

// File: rtl/neighbor_index_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | neighbor_index_allocator                                             |
// | Filters overheard packets, finds or allocates a neighbour slot and   |
// | issues one registered write into the neighbour table.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module neighbor_index_allocator
  import neighbor_pkg::*;
#(
  parameter int                    WORD_WIDTH  = c_word_width,
  parameter int                    NUM_ENTRIES = c_num_entries,
  parameter logic [WORD_WIDTH-1:0] MY_NODE_ID  = WORD_WIDTH'(c_my_node_id)
) (
  input  wire logic                         clk,
  input  wire logic                         nrst,
  input  wire logic                         hb_reset,
  input  wire logic [WORD_WIDTH-1:0]        my_chosen_ch,
  neighbor_index_allocator_if.slave         bus,
  output logic [$clog2(NUM_ENTRIES):0]      neighbor_count,
  output logic                              table_full,
  output logic                              pkt_dropped
);

  localparam int         IW        = $clog2(NUM_ENTRIES);
  localparam logic [IW:0] c_full    = (IW+1)'(NUM_ENTRIES);
  localparam logic [IW:0] c_cnt_one = (IW+1)'(1);

  neighbor_alloc_state_t r_state, w_state_nxt;

  logic [IW:0]           r_count;
  logic [IW-1:0]         r_ptr, w_ptr_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic                  r_wr_new, w_wr_new_nxt;
  logic [IW-1:0]         r_wr_index, w_wr_index_nxt;
  logic                  r_dropped, w_dropped_nxt;
  logic                  w_count_inc, w_count_clr;
  logic                  w_tag_we;
  logic [IW-1:0]         w_tag_widx;
  logic [WORD_WIDTH-1:0] w_tag_wdata;
  logic [WORD_WIDTH-1:0] w_rd_id;

  logic [WORD_WIDTH-1:0] r_node_id, r_chosen_ch, r_hops, r_qvalue, r_energy, r_ch_hops;

  logic w_ready, w_accept, w_filtered, w_hit, w_last;

  // Gated by nrst so every output reads 0 while reset is held.
  assign w_ready    = nrst && (r_state == S_IDLE) && !hb_reset;
  assign w_accept   = bus.pkt_valid && w_ready;
  assign w_filtered = (bus.pkt_node_id == MY_NODE_ID) ||
                      (bus.pkt_chosen_ch != my_chosen_ch);
  assign w_hit      = (w_rd_id == r_node_id);
  assign w_last     = (({1'b0, r_ptr} + c_cnt_one) == r_count);

  neighbor_tag_store #(
    .WORD_WIDTH  (WORD_WIDTH),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_tags (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (w_count_clr),
    .we       (w_tag_we),
    .wr_index (w_tag_widx),
    .wr_data  (w_tag_wdata),
    .rd_index (r_ptr),
    .rd_data  (w_rd_id)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_wr_en_nxt    = 1'b0;
    w_wr_new_nxt   = 1'b0;
    w_wr_index_nxt = r_wr_index;
    w_dropped_nxt  = 1'b0;
    w_count_inc    = 1'b0;
    w_count_clr    = 1'b0;
    w_tag_we       = 1'b0;
    w_tag_widx     = r_count[IW-1:0];
    w_tag_wdata    = r_node_id;

    unique case (r_state)
      S_IDLE: begin
        if (hb_reset) begin
          w_state_nxt = S_CLEAR;
        end else if (w_accept) begin
          if (w_filtered) begin
            w_dropped_nxt = 1'b1;
          end else if (r_count == '0) begin
            // Empty table: nothing to search, allocate slot 0 directly.
            w_state_nxt    = S_WRITE;
            w_wr_en_nxt    = 1'b1;
            w_wr_new_nxt   = 1'b1;
            w_wr_index_nxt = '0;
            w_tag_we       = 1'b1;
            w_tag_widx     = '0;
            w_tag_wdata    = bus.pkt_node_id;
            w_count_inc    = 1'b1;
          end else begin
            w_state_nxt = S_SEARCH;
            w_ptr_nxt   = '0;
          end
        end
      end

      S_SEARCH: begin
        if (hb_reset) begin
          w_state_nxt = S_CLEAR;
        end else if (w_hit) begin
          w_state_nxt    = S_WRITE;
          w_wr_en_nxt    = 1'b1;
          w_wr_index_nxt = r_ptr;
        end else if (w_last) begin
          if (r_count == c_full) begin
            w_state_nxt   = S_IDLE;
            w_dropped_nxt = 1'b1;
          end else begin
            w_state_nxt    = S_WRITE;
            w_wr_en_nxt    = 1'b1;
            w_wr_new_nxt   = 1'b1;
            w_wr_index_nxt = r_count[IW-1:0];
            w_tag_we       = 1'b1;
            w_count_inc    = 1'b1;
          end
        end else begin
          w_ptr_nxt = r_ptr + IW'(1);
        end
      end

      S_WRITE: begin
        w_state_nxt = hb_reset ? S_CLEAR : S_IDLE;
      end

      S_CLEAR: begin
        w_count_clr = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_new    <= 1'b0;
      r_wr_index  <= '0;
      r_dropped   <= 1'b0;
      r_node_id   <= '0;
      r_chosen_ch <= '0;
      r_hops      <= '0;
      r_qvalue    <= '0;
      r_energy    <= '0;
      r_ch_hops   <= '0;
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_new   <= w_wr_new_nxt;
      r_wr_index <= w_wr_index_nxt;
      r_dropped  <= w_dropped_nxt;
      if (w_count_clr)      r_count <= '0;
      else if (w_count_inc) r_count <= r_count + c_cnt_one;
      if (w_accept) begin
        r_node_id   <= bus.pkt_node_id;
        r_chosen_ch <= bus.pkt_chosen_ch;
        r_hops      <= bus.pkt_hops;
        r_qvalue    <= bus.pkt_qvalue;
        r_energy    <= bus.pkt_energy;
        r_ch_hops   <= bus.pkt_ch_hops;
      end
    end
  end

  assign bus.pkt_ready    = w_ready;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_new       = r_wr_new;
  assign bus.wr_index     = r_wr_index;
  assign bus.wr_node_id   = r_node_id;
  assign bus.wr_chosen_ch = r_chosen_ch;
  assign bus.wr_hops      = r_hops;
  assign bus.wr_qvalue    = r_qvalue;
  assign bus.wr_energy    = r_energy;
  assign bus.wr_ch_hops   = r_ch_hops;

  assign neighbor_count = r_count;
  assign table_full     = (r_count == c_full);
  assign pkt_dropped    = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_neighbor_index_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_neighbor_index_allocator                                          |
// | Directed bench for the neighbour index allocator.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_neighbor_index_allocator;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        hb_reset = 1'b0;
  logic [15:0] my_chosen_ch = 16'd3;
  logic [5:0]  neighbor_count;
  logic        table_full;
  logic        pkt_dropped;

  int total = 0;
  int bad   = 0;

  int          wr_cyc, wr_idx, wr_nw, drop_cyc;
  logic [15:0] wr_id;
  logic        seen;

  neighbor_index_allocator_if #(.WORD_WIDTH(16), .NUM_ENTRIES(32)) bus ();

  neighbor_index_allocator #(
    .WORD_WIDTH  (16),
    .NUM_ENTRIES (32),
    .MY_NODE_ID  (16'h000C)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .hb_reset       (hb_reset),
    .my_chosen_ch   (my_chosen_ch),
    .bus            (bus),
    .neighbor_count (neighbor_count),
    .table_full     (table_full),
    .pkt_dropped    (pkt_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] id, input logic [15:0] ch);
    bus.pkt_node_id   = id;
    bus.pkt_chosen_ch = ch;
    bus.pkt_hops      = id + 16'd1;
    bus.pkt_qvalue    = id + 16'd2;
    bus.pkt_energy    = id + 16'd3;
    bus.pkt_ch_hops   = id + 16'd4;
    bus.pkt_valid     = 1'b1;
  endtask

  // Holds valid until ready, then returns 1ns into cycle 1 after the accept edge.
  task automatic accept_held();
    int n = 0;
    while (!bus.pkt_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.pkt_ready) check("ready_wait", {31'd0, bus.pkt_ready}, 32'd1);
    @(posedge clk); #1;
    bus.pkt_valid = 1'b0;
  endtask

  // Watches cycles 1..40 for the first wr_en or pkt_dropped and records the cycle.
  task automatic watch();
    logic done = 1'b0;
    wr_cyc = -1; drop_cyc = -1; wr_idx = -1; wr_nw = -1; wr_id = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.wr_en && wr_cyc < 0) begin
        wr_cyc = c; wr_idx = int'(bus.wr_index); wr_nw = int'(bus.wr_new);
        wr_id  = bus.wr_node_id;
        done   = 1'b1;
      end
      if (pkt_dropped && drop_cyc < 0) begin
        drop_cyc = c;
        done     = 1'b1;
      end
      @(posedge clk); #1;
      if (done) break;
    end
  endtask

  task automatic run(input logic [15:0] id, input logic [15:0] ch);
    drive(id, ch);
    accept_held();
    watch();
  endtask

  initial begin
    bus.pkt_valid = 1'b0;
    drive(16'd0, 16'd0);
    bus.pkt_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en",   {31'd0, bus.wr_en},     32'd0);
    check("rst_count",   {26'd0, neighbor_count}, 32'd0);
    check("rst_full",    {31'd0, table_full},    32'd0);
    check("rst_drop",    {31'd0, pkt_dropped},   32'd0);
    check("rst_ready",   {31'd0, bus.pkt_ready}, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // 1: first id allocates slot 0 straight from idle
    run(16'd5, 16'd3);
    check("t1_wr_cyc", wr_cyc, 32'd1);
    check("t1_wr_idx", wr_idx, 32'd0);
    check("t1_wr_new", wr_nw,  32'd1);
    check("t1_wr_id",  {16'd0, wr_id}, 32'd5);
    check("t1_hops",   {16'd0, bus.wr_hops}, 32'd6);
    check("t1_count",  {26'd0, neighbor_count}, 32'd1);

    // 2: misses append; resend hits
    run(16'd6, 16'd3);
    check("t2_miss6_cyc", wr_cyc, 32'd2);
    check("t2_miss6_idx", wr_idx, 32'd1);
    run(16'd7, 16'd3);
    check("t2_miss7_cyc", wr_cyc, 32'd3);
    check("t2_miss7_idx", wr_idx, 32'd2);
    run(16'd7, 16'd3);
    check("t2_hit7_cyc", wr_cyc, 32'd4);
    check("t2_hit7_idx", wr_idx, 32'd2);
    check("t2_hit7_new", wr_nw,  32'd0);
    check("t2_count",    {26'd0, neighbor_count}, 32'd3);
    run(16'd5, 16'd3);
    check("t2_hit5_cyc", wr_cyc, 32'd2);
    check("t2_hit5_idx", wr_idx, 32'd0);

    // 3: filtered packets
    run(16'h000C, 16'd3);
    check("t3_self_drop", drop_cyc, 32'd1);
    check("t3_self_nowr", wr_cyc,   32'hFFFF_FFFF);
    run(16'd9, 16'd4);
    check("t3_ch_drop",  drop_cyc, 32'd1);
    check("t3_ch_nowr",  wr_cyc,   32'hFFFF_FFFF);
    check("t3_count",    {26'd0, neighbor_count}, 32'd3);

    // 4: fill slots 3..31 with ids 100..128
    for (int k = 0; k < 29; k++) begin
      run(16'(100 + k), 16'd3);
      if (k == 28) begin
        check("t4_last_cyc", wr_cyc, 32'd32);
        check("t4_last_idx", wr_idx, 32'd31);
      end
    end
    check("t4_count", {26'd0, neighbor_count}, 32'd32);
    check("t4_full",  {31'd0, table_full},     32'd1);
    run(16'd200, 16'd3);
    check("t4_full_drop", drop_cyc, 32'd33);
    check("t4_full_nowr", wr_cyc,   32'hFFFF_FFFF);
    check("t4_full_cnt",  {26'd0, neighbor_count}, 32'd32);
    run(16'd7, 16'd3);
    check("t4_ref7_cyc", wr_cyc, 32'd4);
    check("t4_ref7_new", wr_nw,  32'd0);
    run(16'd128, 16'd3);
    check("t4_ref128_cyc", wr_cyc, 32'd33);
    check("t4_ref128_idx", wr_idx, 32'd31);

    // 5: clear, load 5, abort a search with hb_reset in cycle 2
    hb_reset = 1'b1;
    @(posedge clk); #1;
    hb_reset = 1'b0;
    @(posedge clk); #1;
    check("t5_clr_count", {26'd0, neighbor_count}, 32'd0);
    check("t5_clr_full",  {31'd0, table_full},     32'd0);
    for (int k = 0; k < 5; k++) run(16'(40 + k), 16'd3);
    check("t5_count5", {26'd0, neighbor_count}, 32'd5);
    drive(16'd50, 16'd3);
    accept_held();
    seen = 1'b0;
    @(negedge clk); seen |= bus.wr_en;
    @(posedge clk); #1;
    hb_reset = 1'b1;
    @(negedge clk); seen |= bus.wr_en;
    @(posedge clk); #1;
    hb_reset = 1'b0;
    repeat (6) begin
      @(negedge clk); seen |= bus.wr_en | pkt_dropped;
      @(posedge clk); #1;
    end
    check("t5_abort_nowr", {31'd0, seen}, 32'd0);
    check("t5_abort_cnt",  {26'd0, neighbor_count}, 32'd0);
    run(16'd51, 16'd3);
    check("t5_next_cyc", wr_cyc, 32'd1);
    check("t5_next_idx", wr_idx, 32'd0);

    // 6: hb_reset with pkt_valid in idle must not consume the packet
    drive(16'd60, 16'd3);
    hb_reset = 1'b1;
    @(negedge clk);
    check("t6_ready_low", {31'd0, bus.pkt_ready}, 32'd0);
    @(posedge clk); #1;
    hb_reset = 1'b0;
    accept_held();
    watch();
    check("t6_wr_cyc", wr_cyc, 32'd1);
    check("t6_wr_idx", wr_idx, 32'd0);
    check("t6_wr_id",  {16'd0, wr_id}, 32'd60);
    check("t6_count",  {26'd0, neighbor_count}, 32'd1);

    // Asynchronous reset in the middle of a search
    drive(16'd61, 16'd3);
    accept_held();
    #2 nrst = 1'b0;
    #1;
    check("ar_count", {26'd0, neighbor_count}, 32'd0);
    check("ar_wr_en", {31'd0, bus.wr_en},      32'd0);
    seen = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (4) begin
      @(negedge clk); seen |= bus.wr_en;
      @(posedge clk); #1;
    end
    check("ar_nowr",   {31'd0, seen}, 32'd0);
    check("ar_count2", {26'd0, neighbor_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
